// File: rtl/load_store_unit_pkg.sv
// Shared pipeline definitions for the load/store unit.
// Holds the data/address width, the destination register index width, the
// funct3 size encodings, the LSU state encoding and a funct3 legality helper.
package load_store_unit_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned REGADDR = 5;

    typedef enum logic [2:0] {
        F_LB  = 3'b000,
        F_LH  = 3'b001,
        F_LW  = 3'b010,
        F_LBU = 3'b100,
        F_LHU = 3'b101
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    // Only the five B/H/W/BU/HU encodings start a memory access.
    function automatic logic is_legal_size(input logic [2:0] funct3);
        return (funct3 == F_LB) || (funct3 == F_LH) || (funct3 == F_LW) ||
               (funct3 == F_LBU) || (funct3 == F_LHU);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational formatting unit for the load/store unit.
// Store side: replicates store data across byte lanes, builds the write mask,
//   and flags misaligned halfword/word accesses and legal funct3 codes.
// Load side: selects the addressed byte/halfword of the returned word and
//   sign- or zero-extends it according to funct3.
// Ports:
//   st_funct3, st_offset, st_data -> st_wdata, st_wmask, misaligned, legal_size
//   ld_funct3, ld_offset, ld_rdata -> ld_data
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]       st_funct3,
    input  logic [1:0]       st_offset,
    input  logic [WIDTH-1:0] st_data,
    output logic [WIDTH-1:0] st_wdata,
    output logic [3:0]       st_wmask,
    output logic             misaligned,
    output logic             legal_size,
    input  logic [2:0]       ld_funct3,
    input  logic [1:0]       ld_offset,
    input  logic [WIDTH-1:0] ld_rdata,
    output logic [WIDTH-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Access size is carried by funct3[1:0]; bit 2 only selects zero-extension.
    always_comb begin
        legal_size = is_legal_size(st_funct3);
        misaligned = 1'b0;
        st_wdata   = st_data;
        st_wmask   = '0;
        case (st_funct3[1:0])
            2'b00: begin
                st_wdata = {(WIDTH/8){st_data[7:0]}};
                st_wmask = 4'b0001 << st_offset;
            end
            2'b01: begin
                st_wdata   = {(WIDTH/16){st_data[15:0]}};
                st_wmask   = 4'b0011 << st_offset;
                misaligned = st_offset[0];
            end
            2'b10: begin
                st_wmask   = 4'b1111;
                misaligned = (st_offset != 2'b00);
            end
            default: begin
                st_wmask = '0;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[{ld_offset, 3'b000} +: 8];
        ld_half = ld_rdata[{ld_offset[1], 4'b0000} +: 16];
        case (size_t'(ld_funct3))
            F_LB:    ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            F_LH:    ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
            F_LBU:   ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
            F_LHU:   ld_data = {{(WIDTH-16){1'b0}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory.
// Accepts one memory op from execute, issues a valid/ready request to data
// memory, waits for read data on loads and returns a one-cycle writeback beat.
// Ports:
//   clk, rst                       clock, async active-high reset
//   ex_*                           op from execute (valid, load, store, funct3,
//                                  addr, wdata, rd)
//   flush                          kill the in-flight op
//   lsu_stall                      hold upstream stages
//   misalign_exc, misalign_addr    misaligned access report (combinational)
//   dmem_req_*, dmem_we/addr/wdata/wmask   memory request channel
//   dmem_rsp_valid, dmem_rdata     memory read response
//   wb_valid, wb_rd, wb_data       load writeback beat
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = load_store_unit_pkg::WIDTH,
    parameter int unsigned REGADDR = load_store_unit_pkg::REGADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               ex_load,
    input  logic               ex_store,
    input  logic [2:0]         ex_funct3,
    input  logic [WIDTH-1:0]   ex_addr,
    input  logic [WIDTH-1:0]   ex_wdata,
    input  logic [REGADDR-1:0] ex_rd,
    input  logic               flush,
    output logic               lsu_stall,
    output logic               misalign_exc,
    output logic [WIDTH-1:0]   misalign_addr,
    output logic               dmem_req_valid,
    input  logic               dmem_req_ready,
    output logic               dmem_we,
    output logic [WIDTH-1:0]   dmem_addr,
    output logic [WIDTH-1:0]   dmem_wdata,
    output logic [3:0]         dmem_wmask,
    input  logic               dmem_rsp_valid,
    input  logic [WIDTH-1:0]   dmem_rdata,
    output logic               wb_valid,
    output logic [REGADDR-1:0] wb_rd,
    output logic [WIDTH-1:0]   wb_data
);

    lsu_state_t state;
    logic       op_load;
    logic [1:0] op_offset;
    logic [2:0] op_funct3;
    logic       drop;

    logic             op_present;
    logic             accept;
    logic [WIDTH-1:0] st_wdata;
    logic [3:0]       st_wmask;
    logic             misaligned;
    logic             legal_size;
    logic [WIDTH-1:0] ld_data;

    lsu_align u_align (
        .st_funct3  (ex_funct3),
        .st_offset  (ex_addr[1:0]),
        .st_data    (ex_wdata),
        .st_wdata   (st_wdata),
        .st_wmask   (st_wmask),
        .misaligned (misaligned),
        .legal_size (legal_size),
        .ld_funct3  (op_funct3),
        .ld_offset  (op_offset),
        .ld_rdata   (dmem_rdata),
        .ld_data    (ld_data)
    );

    assign op_present = ex_valid && (ex_load || ex_store);
    assign accept     = (state == IDLE) && op_present && legal_size && !misaligned && !flush;

    // Stall already in the IDLE cycle that accepts an op so upstream holds it;
    // released in DONE, where upstream advances.
    assign lsu_stall      = accept || (state == REQ) || (state == WAIT);
    assign dmem_req_valid = (state == REQ);
    assign misalign_exc   = (state == IDLE) && op_present && legal_size && misaligned && !flush;
    assign misalign_addr  = misalign_exc ? ex_addr : '0;
    // Dropped ops never reach DONE, so only a flush in DONE itself gates here.
    assign wb_valid       = (state == DONE) && op_load && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_load    <= 1'b0;
            op_offset  <= '0;
            op_funct3  <= '0;
            drop       <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wmask <= '0;
            wb_rd      <= '0;
            wb_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_load    <= ex_load;
                        op_offset  <= ex_addr[1:0];
                        op_funct3  <= ex_funct3;
                        wb_rd      <= ex_rd;
                        drop       <= 1'b0;
                        dmem_we    <= !ex_load;
                        dmem_addr  <= {2'b00, ex_addr[WIDTH-1:2]};
                        dmem_wdata <= ex_load ? '0 : st_wdata;
                        dmem_wmask <= ex_load ? '0 : st_wmask;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        if (op_load) begin
                            drop  <= flush;
                            state <= WAIT;
                        end else begin
                            state <= flush ? IDLE : DONE;
                        end
                    end else if (flush) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (dmem_rsp_valid) begin
                        if (drop || flush) begin
                            state <= IDLE;
                        end else begin
                            wb_data <= ld_data;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_load, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        lsu_stall, misalign_exc;
    logic [31:0] misalign_addr;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .REGADDR(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .flush(flush), .lsu_stall(lsu_stall),
        .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: extract the addressed byte/halfword arithmetically and extend.
    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [31:0] b, h;
        shifted = rdata >> (8 * (a % 4));
        b = shifted & 32'hFF;
        h = shifted & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input int unsigned nbytes, input logic [31:0] wd);
        if (nbytes == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (nbytes == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // One complete op: IDLE presentation, REQ with backpressure, WAIT, DONE.
    task automatic run_op(input bit ld, input bit st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                          input int unsigned rdy_dly, input int unsigned rsp_dly);
        int unsigned nb;
        bit legal, mis, go;
        logic [31:0] exp_mask, exp_wdata;
        nb        = 1 << (f % 4);
        legal     = (f == 0) || (f == 1) || (f == 2) || (f == 4) || (f == 5);
        mis       = legal && ((a % nb) != 0);
        go        = legal && !mis;
        exp_mask  = ld ? 32'd0 : ((((32'd1 << nb) - 1) << (a % 4)) & 32'hF);
        exp_wdata = ld ? 32'd0 : model_wdata(nb, wd);

        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f;
        ex_addr = a; ex_wdata = wd; ex_rd = rd;
        #1;
        check("idle_stall", lsu_stall, go);
        check("idle_exc", misalign_exc, mis);
        check("idle_exc_addr", misalign_addr, mis ? a : 32'd0);
        check("idle_req", dmem_req_valid, 1'b0);
        tick();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        ex_addr = $urandom; ex_wdata = $urandom;
        if (go) begin
            for (int unsigned i = 0; i <= rdy_dly; i++) begin
                dmem_req_ready = (i == rdy_dly);
                #1;
                check("req_valid", dmem_req_valid, 1'b1);
                check("req_we", dmem_we, !ld);
                check("req_addr", dmem_addr, a >> 2);
                check("req_wmask", dmem_wmask, exp_mask);
                check("req_wdata", dmem_wdata, exp_wdata);
                check("req_stall", lsu_stall, 1'b1);
                tick();
            end
            dmem_req_ready = 1'b0;
            if (ld) begin
                for (int unsigned i = 0; i <= rsp_dly; i++) begin
                    dmem_rsp_valid = (i == rsp_dly);
                    dmem_rdata = (i == rsp_dly) ? rdata : $urandom;
                    #1;
                    check("wait_stall", lsu_stall, 1'b1);
                    check("wait_wb", wb_valid, 1'b0);
                    check("wait_req", dmem_req_valid, 1'b0);
                    tick();
                end
                dmem_rsp_valid = 1'b0;
                dmem_rdata = $urandom;
            end
            #1;
            check("done_stall", lsu_stall, 1'b0);
            check("done_wb_valid", wb_valid, ld);
            if (ld) begin
                check("done_wb_rd", wb_rd, rd);
                check("done_wb_data", wb_data, model_load(f, a, rdata));
            end
            tick();
        end
        #1;
        check("post_stall", lsu_stall, 1'b0);
        check("post_wb", wb_valid, 1'b0);
        check("post_req", dmem_req_valid, 1'b0);
    endtask

    initial begin
        logic [2:0] ld_codes [7];
        ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

        rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = '0;
        ex_addr = '0; ex_wdata = '0; ex_rd = '0; flush = 1'b0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
        #2;
        check("rst_stall", lsu_stall, 1'b0);
        check("rst_req", dmem_req_valid, 1'b0);
        check("rst_wb", wb_valid, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // SW, ready high, LB/LBU sign vs zero, SH with backpressure, misaligned LW
        run_op(1'b0, 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 5'd0, 32'd0, 0, 0);
        run_op(1'b1, 1'b0, 3'd0, 32'h203, 32'd0, 5'd9, 32'h80112233, 0, 0);
        run_op(1'b1, 1'b0, 3'd4, 32'h203, 32'd0, 5'd10, 32'h80112233, 0, 0);
        run_op(1'b0, 1'b1, 3'd1, 32'h12, 32'h0000ABCD, 5'd0, 32'd0, 3, 0);
        run_op(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 5'd3, 32'd0, 0, 0);
        run_op(1'b1, 1'b1, 3'd5, 32'h7E, 32'd0, 5'd31, 32'h8001_F00D, 1, 2);
        run_op(1'b0, 1'b1, 3'd3, 32'h40, 32'h1234, 5'd0, 32'd0, 0, 0);

        // Flush in WAIT one cycle before the response: drained, no writeback
        ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'd1; ex_addr = 32'h20; ex_rd = 5'd4;
        tick();
        ex_valid = 1'b0; ex_load = 1'b0; dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0; flush = 1'b1;
        #1;
        check("fw_stall0", lsu_stall, 1'b1);
        tick();
        flush = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        #1;
        check("fw_stall1", lsu_stall, 1'b1);
        check("fw_wb1", wb_valid, 1'b0);
        tick();
        dmem_rsp_valid = 1'b0;
        #1;
        check("fw_idle_stall", lsu_stall, 1'b0);
        check("fw_idle_wb", wb_valid, 1'b0);
        check("fw_idle_req", dmem_req_valid, 1'b0);

        // Flush in REQ before acceptance drops the request
        ex_valid = 1'b1; ex_store = 1'b1; ex_funct3 = 3'd0; ex_addr = 32'h33; ex_wdata = 32'h7F;
        tick();
        ex_valid = 1'b0; ex_store = 1'b0; flush = 1'b1;
        #1;
        check("fr_req", dmem_req_valid, 1'b1);
        check("fr_mask", dmem_wmask, 32'h8);
        tick();
        flush = 1'b0;
        #1;
        check("fr_req_gone", dmem_req_valid, 1'b0);
        check("fr_stall", lsu_stall, 1'b0);

        // Flush in DONE suppresses the writeback beat
        ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'd2; ex_addr = 32'h80; ex_rd = 5'd6;
        tick();
        ex_valid = 1'b0; ex_load = 1'b0; dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFE_0001;
        tick();
        dmem_rsp_valid = 1'b0; flush = 1'b1;
        #1;
        check("fd_wb", wb_valid, 1'b0);
        check("fd_stall", lsu_stall, 1'b0);
        tick();
        flush = 1'b0;

        // Reset in WAIT: immediate IDLE, stray response ignored
        ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'd0; ex_addr = 32'h45; ex_rd = 5'd12;
        tick();
        ex_valid = 1'b0; ex_load = 1'b0; dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        #1;
        check("rw_stall_before", lsu_stall, 1'b1);
        rst = 1'b1;
        #1;
        check("rw_stall", lsu_stall, 1'b0);
        check("rw_req", dmem_req_valid, 1'b0);
        check("rw_addr", dmem_addr, 32'd0);
        check("rw_wb_rd", wb_rd, 32'd0);
        check("rw_wb_data", wb_data, 32'd0);
        tick();
        rst = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_rsp_valid = 1'b0;
        #1;
        check("rw_stray_wb", wb_valid, 1'b0);
        check("rw_stray_stall", lsu_stall, 1'b0);

        // Randomized ops against the reference model
        for (int n = 0; n < 60; n++) begin
            int unsigned kind;
            logic [2:0] f;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = $urandom;
            if (kind == 1) f = 3'($urandom_range(0, 2));
            else f = ld_codes[$urandom_range(0, 6)];
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << (f % 4)) - 1);
            run_op(kind != 1, kind != 0, f, a, $urandom, 5'($urandom), $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the data-memory stage; owns every load and store the pipeline issues.
- Converts the byte address and funct3 into a word address, a byte-lane write mask and replicated store data.
- Runs a valid/ready request to data memory, then sign- or zero-extends the returned word into a one-cycle writeback beat.
- Detects misaligned accesses and stalls the pipeline while an access is outstanding.

Parameters:
- WIDTH, 32, data/address width (from pipeline package)
- REGADDR, 5, destination register index width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  execute stage presents a memory op this cycle
- ex_load  in  1  op is a load
- ex_store  in  1  op is a store
- ex_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr  in  WIDTH  byte address
- ex_wdata  in  WIDTH  store source (rs2)
- ex_rd  in  REGADDR  load destination
- flush  in  1  kill in-flight op (branch/trap)
- lsu_stall  out  1  hold upstream stages
- misalign_exc  out  1  misaligned access, combinational
- misalign_addr  out  WIDTH  faulting byte address
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  1  request is a write
- dmem_addr  out  WIDTH  word address, ex_addr[WIDTH-1:2]
- dmem_wdata  out  WIDTH  lane-replicated store data
- dmem_wmask  out  4  byte-lane enables
- dmem_rsp_valid  in  1  read data valid; never in the same cycle the request is accepted
- dmem_rdata  in  WIDTH  read word
- wb_valid  out  1  load result valid, one cycle
- wb_rd  out  REGADDR  load destination
- wb_data  out  WIDTH  extended load data

Behaviour:
- **Reset.** clk only, one clock domain. rst is asynchronous and active-high. On reset: state IDLE, every registered output 0, op registers cleared. Reset mid-operation abandons the op; a later dmem_rsp_valid seen in IDLE is ignored.
- **State IDLE.**
  - An op is present when ex_valid && (ex_load || ex_store). If both load and store are set, treat it as a load.
  - Misaligned means H with addr[0]==1, or W with addr[1:0]!=0.
  - Misaligned op: misalign_exc=1 and misalign_addr=ex_addr in that same cycle. No request is issued, lsu_stall=0, state stays IDLE.
  - funct3 011/110/111: no access, no stall, no exception.
  - Legal op: latch op, addr, wdata, rd and funct3; lsu_stall=1; next state REQ.
- **State REQ.**
  - dmem_req_valid=1. dmem_we, dmem_addr, dmem_wdata and dmem_wmask are driven from the latched op and stay stable until accepted.
  - On dmem_req_ready: a store goes to DONE, a load goes to WAIT. lsu_stall=1.
- **State WAIT.**
  - lsu_stall=1.
  - On dmem_rsp_valid: select lane addr[1:0], extend per funct3, latch into wb_data, go to DONE.
- **State DONE.**
  - lsu_stall=0.
  - wb_valid=1 for loads only, with wb_rd and wb_data held from the latch. Next state IDLE.
  - Upstream advances at the end of this cycle.
- **Store formatting.**
  - SB: wdata={4{b}}, wmask=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wmask=4'b0011<<addr[1:0].
  - SW: wmask=4'b1111.
- **Load formatting.**
  - byte = rdata[8*addr[1:0] +: 8], halfword = rdata[16*addr[1] +: 16].
  - Signed formats replicate the MSB; unsigned formats zero-fill.
- **Flush.**
  - In IDLE: the op is not accepted.
  - In REQ before acceptance: drop the request, go IDLE.
  - In REQ on the same cycle as acceptance, or in WAIT: set a drop flag. A store returns to IDLE. A load waits in WAIT for its response, discards it (wb_valid stays 0), then goes IDLE. lsu_stall stays asserted while draining.
  - In DONE: suppress wb_valid.
- **Latency (no backpressure).** Store: 3 cycles, IDLE→REQ→DONE. Load with response one cycle after acceptance: 4 cycles.

Decomposition:
- **Shared package (pipeline package):** WIDTH, REGADDR, a funct3 size enum (LB/LH/LW/LBU/LHU) and an lsu_state_t enum (IDLE, REQ, WAIT, DONE).
- **Sub-module lsu_align:** a combinational store-formatting/mask and load-extract/extend unit, plus the misalign check, instantiated once. The FSM and op registers stay in load_store_unit.

Test Plan:
- **SW, ready tied high:** addr=0x104, wdata=0xDEADBEEF. Expect cycle 1: req_valid, we=1, dmem_addr=0x41, wmask=1111. Cycle 2: DONE, stall low, wb_valid=0.
- **LB signed:** addr=0x203, rdata=0x80112233 one cycle after accept. Expect wb_data=0xFFFFFF80, wb_valid one cycle, wb_rd=ex_rd. The same access as LBU gives 0x00000080.
- **SH backpressure:** addr=0x12, wdata=0x0000ABCD, ready low 3 cycles. Expect REQ outputs stable, wmask=1100, wdata=0xABCDABCD, stall high throughout, DONE after ready.
- **Misaligned LW:** addr=0x101. Expect misalign_exc=1, misalign_addr=0x101 that cycle, no req_valid ever, stall=0.
- **Flush in WAIT:** LH addr=0x20, flush one cycle before rsp_valid. Expect stall held until response, wb_valid never asserted, IDLE next cycle.
- **Reset in WAIT:** assert rst mid-op. Expect immediate IDLE with all outputs 0. A subsequent stray rsp_valid produces no wb_valid.
